// File: rtl/screen_draw_ctrl.sv
// Drawing controller for a single VGA adapter write port: full-screen image fills
// streamed from a synchronous image ROM, and 4x4 game-cell paints.
module screen_draw_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        fill_req,
    input  logic [1:0]  fill_sel,
    input  logic        blk_req,
    input  logic [5:0]  blk_x,
    input  logic [4:0]  blk_y,
    input  logic [2:0]  blk_colour,
    output logic [1:0]  rom_sel,
    output logic [14:0] rom_addr,
    input  logic [2:0]  rom_q,
    output logic [7:0]  x,
    output logic [6:0]  y,
    output logic [2:0]  colour,
    output logic        plot,
    output logic        busy,
    output logic        fill_done,
    output logic        blk_done
);

    typedef enum logic [1:0] {StIdle, StFill, StFillDrain, StBlock} state_e;

    localparam logic [7:0] XLast = 8'd159;
    localparam logic [6:0] YLast = 7'd119;
    localparam logic [5:0] BlkXMax = 6'd39;
    localparam logic [4:0] BlkYMax = 5'd29;

    state_e      state_q, state_d;
    logic [1:0]  sel_q, sel_d;
    logic [14:0] addr_q, addr_d;
    logic [7:0]  fx_q, fx_d;
    logic [6:0]  fy_q, fy_d;
    logic [7:0]  px_q, px_d;
    logic [6:0]  py_q, py_d;
    logic        fplot_q, fplot_d;
    logic [5:0]  bx_q, bx_d;
    logic [4:0]  by_q, by_d;
    logic [2:0]  bc_q, bc_d;
    logic        bad_q, bad_d;
    logic [3:0]  i_q, i_d;
    logic [7:0]  hx_q, hx_d;
    logic [6:0]  hy_q, hy_d;
    logic [2:0]  hc_q, hc_d;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        addr_d  = addr_q;
        fx_d    = fx_q;
        fy_d    = fy_q;
        bx_d    = bx_q;
        by_d    = by_q;
        bc_d    = bc_q;
        bad_d   = bad_q;
        i_d     = i_q;
        // ROM data lags the address by one cycle, so the plotted pixel is last cycle's address
        fplot_d = (state_q == StFill);
        px_d    = fx_q;
        py_d    = fy_q;
        unique case (state_q)
            StIdle: begin
                if (fill_req) begin
                    state_d = StFill;
                    sel_d   = fill_sel;
                    addr_d  = '0;
                    fx_d    = '0;
                    fy_d    = '0;
                end else if (blk_req) begin
                    state_d = StBlock;
                    bx_d    = blk_x;
                    by_d    = blk_y;
                    bc_d    = blk_colour;
                    i_d     = '0;
                    bad_d   = (blk_x > BlkXMax) || (blk_y > BlkYMax);
                end
            end
            StFill: begin
                if (fx_q == XLast && fy_q == YLast) begin
                    state_d = StFillDrain;
                end else begin
                    addr_d = addr_q + 15'd1;
                    if (fx_q == XLast) begin
                        fx_d = '0;
                        fy_d = fy_q + 7'd1;
                    end else begin
                        fx_d = fx_q + 8'd1;
                    end
                end
            end
            StFillDrain: state_d = StIdle;
            StBlock: begin
                i_d = i_q + 4'd1;
                if (bad_q || i_q == 4'hF) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Write-port mux; the held copy keeps x/y/colour stable whenever nothing is plotted
    always_comb begin
        x      = hx_q;
        y      = hy_q;
        colour = hc_q;
        plot   = 1'b0;
        if (state_q == StBlock && !bad_q) begin
            x      = {bx_q, i_q[1:0]};
            y      = {by_q, i_q[3:2]};
            colour = bc_q;
            plot   = 1'b1;
        end else if (fplot_q) begin
            x      = px_q;
            y      = py_q;
            colour = rom_q;
            plot   = 1'b1;
        end
        hx_d = plot ? x : hx_q;
        hy_d = plot ? y : hy_q;
        hc_d = plot ? colour : hc_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            sel_q   <= '0;
            addr_q  <= '0;
            fx_q    <= '0;
            fy_q    <= '0;
            px_q    <= '0;
            py_q    <= '0;
            fplot_q <= 1'b0;
            bx_q    <= '0;
            by_q    <= '0;
            bc_q    <= '0;
            bad_q   <= 1'b0;
            i_q     <= '0;
            hx_q    <= '0;
            hy_q    <= '0;
            hc_q    <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            addr_q  <= addr_d;
            fx_q    <= fx_d;
            fy_q    <= fy_d;
            px_q    <= px_d;
            py_q    <= py_d;
            fplot_q <= fplot_d;
            bx_q    <= bx_d;
            by_q    <= by_d;
            bc_q    <= bc_d;
            bad_q   <= bad_d;
            i_q     <= i_d;
            hx_q    <= hx_d;
            hy_q    <= hy_d;
            hc_q    <= hc_d;
        end
    end

    assign rom_sel   = sel_q;
    assign rom_addr  = addr_q;
    assign busy      = (state_q != StIdle);
    assign fill_done = (state_q == StFillDrain);
    assign blk_done  = (state_q == StBlock) && (bad_q || i_q == 4'hF);

endmodule

// File: tb/tb_screen_draw_ctrl.sv
// Directed bench for screen_draw_ctrl: table of block paints plus hand-written fill,
// arbitration, reset and re-request sequences, against a ROM returning addr[2:0].
module tb_screen_draw_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        fill_req;
    logic [1:0]  fill_sel;
    logic        blk_req;
    logic [5:0]  blk_x;
    logic [4:0]  blk_y;
    logic [2:0]  blk_colour;
    logic [1:0]  rom_sel;
    logic [14:0] rom_addr;
    logic [2:0]  rom_q = 3'd0;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  colour;
    logic        plot;
    logic        busy;
    logic        fill_done;
    logic        blk_done;

    screen_draw_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .fill_req   (fill_req),
        .fill_sel   (fill_sel),
        .blk_req    (blk_req),
        .blk_x      (blk_x),
        .blk_y      (blk_y),
        .blk_colour (blk_colour),
        .rom_sel    (rom_sel),
        .rom_addr   (rom_addr),
        .rom_q      (rom_q),
        .x          (x),
        .y          (y),
        .colour     (colour),
        .plot       (plot),
        .busy       (busy),
        .fill_done  (fill_done),
        .blk_done   (blk_done)
    );

    always #5 clk = ~clk;

    // Synchronous image ROM: data one cycle after the address
    always @(posedge clk) rom_q <= rom_addr[2:0];

    typedef struct {
        int bx;
        int by;
        int bc;
        int exp_plots;
        int exp_done;
        int last_x;
        int last_y;
    } vec_t;

    vec_t vecs[6];
    int checks = 0;
    int errors = 0;

    int n_plot, n_busy, n_bad, n_done, done_cyc, addr0, sel1;
    bit timeout;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Called at the negedge of an IDLE cycle with the request already high.
    // mode: 0 keep request, 1 drop it at done, 2 drop it right after acceptance.
    task automatic run_op(input bit is_fill, input int bx, input int by, input int bc,
                          input int mode, input int limit);
        logic [1:0] o_sel;
        logic [5:0] o_bx;
        logic [4:0] o_by;
        logic [2:0] o_bc;
        int ex, ey, ec;
        n_plot = 0; n_busy = 0; n_bad = 0; n_done = 0; done_cyc = -1;
        addr0 = -1; sel1 = -1; timeout = 1'b1;
        o_sel = fill_sel; o_bx = blk_x; o_by = blk_y; o_bc = blk_colour;
        for (int c = 0; c < limit; c++) begin
            @(negedge clk);
            if (c == 0) begin
                addr0 = int'(rom_addr);
                fill_sel = ~fill_sel;
                blk_x = ~blk_x;
                blk_y = ~blk_y;
                blk_colour = ~blk_colour;
                if (mode == 2) begin
                    if (is_fill) fill_req = 1'b0;
                    else blk_req = 1'b0;
                end
            end
            if (c == 1) sel1 = int'(rom_sel);
            if (busy) n_busy++;
            if (plot) begin
                if (is_fill) begin
                    ex = n_plot % 160; ey = n_plot / 160; ec = n_plot % 8;
                end else begin
                    ex = bx * 4 + n_plot % 4; ey = by * 4 + n_plot / 4; ec = bc;
                end
                if (int'(x) != ex || int'(y) != ey || int'(colour) != ec) n_bad++;
                n_plot++;
            end
            if (is_fill ? blk_done : fill_done) n_bad++;
            if (is_fill ? fill_done : blk_done) begin
                n_done++;
                done_cyc = c;
                timeout = 1'b0;
                fill_sel = o_sel; blk_x = o_bx; blk_y = o_by; blk_colour = o_bc;
                if (mode == 1) begin
                    if (is_fill) fill_req = 1'b0;
                    else blk_req = 1'b0;
                end
                break;
            end
        end
    endtask

    task automatic check_op(input string tag, input int exp_plots, input int exp_done);
        check($sformatf("%s timeout", tag), int'(timeout), 0);
        check($sformatf("%s plots", tag), n_plot, exp_plots);
        check($sformatf("%s done_cycle", tag), done_cyc, exp_done);
        check($sformatf("%s busy_cycles", tag), n_busy, exp_done + 1);
        check($sformatf("%s pixel_errors", tag), n_bad, 0);
    endtask

    task automatic idle_check(input string tag);
        @(negedge clk);
        check($sformatf("%s idle busy", tag), int'(busy), 0);
        check($sformatf("%s idle plot", tag), int'(plot), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check($sformatf("%s plot", tag), int'(plot), 0);
        check($sformatf("%s busy", tag), int'(busy), 0);
        check($sformatf("%s dones", tag), int'({fill_done, blk_done}), 0);
        check($sformatf("%s rom_addr", tag), int'(rom_addr), 0);
        check($sformatf("%s rom_sel", tag), int'(rom_sel), 0);
        check($sformatf("%s xy_colour", tag), int'({x, y, colour}), 0);
    endtask

    initial begin
        vecs[0] = '{bx: 0,  by: 0,  bc: 3, exp_plots: 16, exp_done: 15, last_x: 3,   last_y: 3};
        vecs[1] = '{bx: 39, by: 29, bc: 4, exp_plots: 16, exp_done: 15, last_x: 159, last_y: 119};
        vecs[2] = '{bx: 17, by: 5,  bc: 7, exp_plots: 16, exp_done: 15, last_x: 71,  last_y: 23};
        vecs[3] = '{bx: 40, by: 0,  bc: 2, exp_plots: 0,  exp_done: 0,  last_x: 0,   last_y: 0};
        vecs[4] = '{bx: 0,  by: 30, bc: 1, exp_plots: 0,  exp_done: 0,  last_x: 0,   last_y: 0};
        vecs[5] = '{bx: 63, by: 31, bc: 5, exp_plots: 0,  exp_done: 0,  last_x: 0,   last_y: 0};

        rst = 1'b1; fill_req = 1'b0; fill_sel = 2'd0; blk_req = 1'b0;
        blk_x = '0; blk_y = '0; blk_colour = '0;
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b1;
        idle_check("post_reset");

        // Full fill with image 2
        fill_sel = 2'd2; fill_req = 1'b1;
        run_op(1'b1, 0, 0, 0, 1, 19300);
        check_op("fill_sel2", 19200, 19200);
        check("fill_sel2 first_addr", addr0, 0);
        check("fill_sel2 rom_sel", sel1, 2);
        check("fill_sel2 rom_sel_latched", int'(rom_sel), 2);
        idle_check("fill_sel2");

        foreach (vecs[k]) begin
            blk_x = 6'(vecs[k].bx); blk_y = 5'(vecs[k].by); blk_colour = 3'(vecs[k].bc);
            blk_req = 1'b1;
            run_op(1'b0, vecs[k].bx, vecs[k].by, vecs[k].bc, 1, 40);
            check_op($sformatf("blk%0d", k), vecs[k].exp_plots, vecs[k].exp_done);
            idle_check($sformatf("blk%0d", k));
            if (vecs[k].exp_plots > 0) begin
                check($sformatf("blk%0d hold_x", k), int'(x), vecs[k].last_x);
                check($sformatf("blk%0d hold_y", k), int'(y), vecs[k].last_y);
                check($sformatf("blk%0d hold_colour", k), int'(colour), vecs[k].bc);
            end
        end
        @(negedge clk);
        check("no_reserve busy", int'(busy), 0);

        // Simultaneous requests: fill first, block after one idle cycle
        fill_sel = 2'd3; fill_req = 1'b1;
        blk_x = 6'd2; blk_y = 5'd3; blk_colour = 3'd6; blk_req = 1'b1;
        run_op(1'b1, 0, 0, 0, 1, 19300);
        check_op("arb_fill", 19200, 19200);
        check("arb_fill rom_sel", sel1, 3);
        idle_check("arb_gap");
        run_op(1'b0, 2, 3, 6, 1, 40);
        check_op("arb_blk", 16, 15);
        idle_check("arb_blk");

        // Requester holds blk_req one cycle past blk_done
        blk_x = 6'd10; blk_y = 5'd20; blk_colour = 3'd2; blk_req = 1'b1;
        run_op(1'b0, 10, 20, 2, 0, 40);
        check_op("rereq1", 16, 15);
        idle_check("rereq_gap");
        run_op(1'b0, 10, 20, 2, 2, 40);
        check_op("rereq2", 16, 15);
        idle_check("rereq2");
        @(negedge clk);
        check("rereq2 no_third busy", int'(busy), 0);

        // Reset in the middle of a fill, request held through it
        fill_sel = 2'd1; fill_req = 1'b1;
        repeat (5001) @(negedge clk);
        check("midfill plot", int'(plot), 1);
        check("midfill rom_addr", int'(rom_addr), 5000);
        rst = 1'b0;
        #1;
        check_all_zero("async_reset");
        @(negedge clk);
        rst = 1'b1;
        run_op(1'b1, 0, 0, 0, 1, 19300);
        check("restart first_addr", addr0, 0);
        check_op("restart", 19200, 19200);
        check("restart rom_sel", sel1, 1);
        idle_check("restart");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/screen_draw_ctrl.md
SCREEN_DRAW_CTRL -- requirements
Module: screen_draw_ctrl

Interface
REQ-001 SHALL: clk  in  1  system clock; all state changes on rising edge.
REQ-002 SHALL: rst  in  1  reset, asynchronous, active-low.
REQ-003 SHALL: fill_req  in  1  level request for a full-screen image fill; held until fill_done.
REQ-004 SHALL: fill_sel  in  2  image select: 0 black, 1 red, 2 title, 3 game-over.
REQ-005 SHALL: blk_req  in  1  level request to paint one 4x4 game cell; held until blk_done.
REQ-006 SHALL: blk_x  in  6  cell column, valid 0..39.
REQ-007 SHALL: blk_y  in  5  cell row, valid 0..29.
REQ-008 SHALL: blk_colour  in  3  cell colour.
REQ-009 SHALL: rom_sel  out  2  image ROM select, latched copy of fill_sel.
REQ-010 SHALL: rom_addr  out  15  pixel address = y*160 + x, range 0..19199.
REQ-011 SHALL: rom_q  in  3  ROM pixel colour, valid one cycle after rom_addr.
REQ-012 SHALL: x  out  8, y  out  7, colour  out  3, plot  out  1: single VGA adapter write port.
REQ-013 SHALL: busy  out  1  high in any state other than IDLE.
REQ-014 SHALL: fill_done  out  1, blk_done  out  1: one-cycle completion pulses.

Function
REQ-015 SHALL: FSM states IDLE, FILL, FILL_DRAIN, BLOCK; serve one request at a time.
REQ-016 SHALL: sample requests only in IDLE; if fill_req and blk_req are both high, fill wins and blk_req waits.
REQ-017 SHALL: on fill acceptance, latch fill_sel into rom_sel; fill_sel changes during a fill are ignored.
REQ-018 SHALL: in FILL, issue rom_addr k in cycle k (k = 0..19199), with x-major raster order (x 0..159 inner, y 0..119 outer); rom_addr advances incrementally, with no multiplier.
REQ-019 SHALL: in cycle k+1, drive plot=1 with x, y of address k and colour=rom_q (one-cycle pipeline).
REQ-020 SHALL: after issuing address 19199, enter FILL_DRAIN for one cycle to plot the last pixel (159,119) with fill_done=1, then go to IDLE; a fill is busy for exactly 19201 cycles.
REQ-021 SHALL: on block acceptance, latch blk_x, blk_y and blk_colour; later input changes are ignored.
REQ-022 SHALL: in BLOCK, run a 4-bit counter i = 0..15 for 16 cycles with plot=1, x = blk_x*4 + i[1:0], y = blk_y*4 + i[3:2], colour = latched colour.
REQ-023 SHALL: assert blk_done in the i=15 cycle, then go to IDLE.
REQ-024 SHALL: if blk_x>39 or blk_y>29 at acceptance, plot nothing; assert blk_done in the single cycle after acceptance, then go to IDLE.
REQ-025 SHALL: assert done in the last busy cycle so that a requester dropping its request on that edge is not re-served; a request still high in the following IDLE cycle is accepted again.
REQ-026 SHALL: when plot=0, hold x, y and colour at their last values.
REQ-027 SHALL: produce no plot during the IDLE cycle or the acceptance edge; first plot of a block occurs in the first BLOCK cycle.

Reset
REQ-028 SHALL: while rst=0, force state IDLE and x, y, colour, plot, busy, fill_done, blk_done, rom_addr and rom_sel all to 0, asynchronously, including mid-fill or mid-block.
REQ-029 SHALL: after rst release, discard any interrupted operation; a still-asserted request is served from its start.

Verification
REQ-030 SHALL: cover fill_req=1 with fill_sel=2 and a ROM model returning addr[2:0] -> 19200 plots, pixel (x,y) colour = (y*160+x)[2:0], fill_done once in cycle 19200, busy 19201 cycles.
REQ-031 SHALL: cover blk_req with blk_x=39, blk_y=29 and colour 4 -> 16 plots covering x 156..159 and y 116..119, colour 4, blk_done with the 16th plot.
REQ-032 SHALL: cover fill_req and blk_req rising in the same cycle -> full fill first, then the block starts in the cycle after the IDLE cycle following fill_done.
REQ-033 SHALL: cover blk_x=40 -> zero plots, blk_done one cycle after acceptance, busy for 1 cycle.
REQ-034 SHALL: cover rst low at fill pixel 5000 -> plot, busy and all outputs 0 within the same cycle; after release with fill_req held, the fill restarts at rom_addr 0.
REQ-035 SHALL: cover a requester holding blk_req one cycle past blk_done -> the second block is served, with identical coordinates.
